// File: rtl/sym_stream_sequencer.sv
// sym_stream_sequencer
//   Upstream stage for the two-state colour Mealy FSM. Symbol commands
//   {sym, len} are queued in a small FIFO. Each command is replayed as a run
//   of len+1 identical 2-bit symbols, one per clock, on sym_out. Between runs
//   the idle symbol is driven so the downstream FSM holds its state.
//
// Handshake: a command transfers on any rising clk edge where
//   cmd_valid && cmd_ready. cmd_ready depends only on the FIFO level, never on
//   cmd_valid. cmd_valid/cmd_sym/cmd_len are sampled only on that edge.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   flush      in   synchronous clear of FIFO and current run (drops a same-edge push)
//   cmd_valid  in   command offered
//   cmd_ready  out  FIFO has room (level != DEPTH)
//   cmd_sym    in   symbol to emit
//   cmd_len    in   run length minus one (0 -> one cycle)
//   sym_out    out  registered symbol to the FSM `in` port
//   sym_valid  out  high while a run symbol is on sym_out
//   busy       out  run active or FIFO non-empty
//   level      out  FIFO occupancy
module sym_stream_sequencer #(
   parameter int         DEPTH    = 4,
   parameter int         CNT_W    = 4,
   parameter logic [1:0] IDLE_SYM = 2'h3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [1:0]                   cmd_sym,
   input  logic [CNT_W-1:0]             cmd_len,
   output logic [1:0]                   sym_out,
   output logic                         sym_valid,
   output logic                         busy,
   output logic [$clog2(DEPTH+1)-1:0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam int LW = $clog2(DEPTH+1);
   localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);

   typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

   state_t                 state_q, state_d;
   logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [1:0]             sym_out_q, sym_out_d;
   logic                   sym_valid_q, sym_valid_d;
   logic [CNT_W+1:0]       mem_q [DEPTH];

   logic                   empty;
   logic                   push;
   logic                   pop;
   logic [CNT_W+1:0]       head;
   logic [PW-1:0]          ptr_diff;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty     = (wr_ptr_q == rd_ptr_q);
   assign ptr_diff  = wr_ptr_q - rd_ptr_q;
   assign level     = LW'(ptr_diff);
   assign cmd_ready = (level != DEPTH_LVL);
   assign head      = mem_q[rd_ptr_q[AW-1:0]];

   // A push coinciding with flush is discarded.
   assign push = cmd_valid && cmd_ready && !flush;
   // Load the next command when idle, or on the last cycle of the current
   // run so consecutive runs follow without a gap.
   assign pop  = !flush && !empty && ((state_q == ST_IDLE) || (cnt_q == '0));

   assign wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(push);
   assign rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(pop);

   // State register (with output/datapath flops)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         sym_out_q   <= IDLE_SYM;
         sym_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         sym_out_q   <= sym_out_d;
         sym_valid_q <= sym_valid_d;
      end
   end

   // Command storage needs no reset; entries are only read once written.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {cmd_sym, cmd_len};
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (!empty) state_d = ST_RUN;
            ST_RUN:  if ((cnt_q == '0) && empty) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Output / datapath logic
   always_comb begin
      sym_out_d   = sym_out_q;
      sym_valid_d = sym_valid_q;
      cnt_d       = cnt_q;
      if (flush) begin
         sym_out_d   = IDLE_SYM;
         sym_valid_d = 1'b0;
         cnt_d       = '0;
      end else if (pop) begin
         sym_out_d   = head[CNT_W+1:CNT_W];
         sym_valid_d = 1'b1;
         cnt_d       = head[CNT_W-1:0];
      end else if (state_q == ST_RUN) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
         end else begin
            sym_out_d   = IDLE_SYM;
            sym_valid_d = 1'b0;
         end
      end
   end

   assign sym_out   = sym_out_q;
   assign sym_valid = sym_valid_q;
   assign busy      = (state_q == ST_RUN) || (level != '0);

endmodule

// File: tb/tb_sym_stream_sequencer.sv
module tb_sym_stream_sequencer;

   localparam int         DEPTH = 4;
   localparam int         CNT_W = 4;
   localparam logic [1:0] IDLE  = 2'h3;

   // ---------------- clock / reset ----------------
   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             cmd_valid = 1'b0;
   logic [1:0]       cmd_sym = 2'd0;
   logic [CNT_W-1:0] cmd_len = '0;
   logic             cmd_ready;
   logic [1:0]       sym_out;
   logic             sym_valid;
   logic             busy;
   logic [2:0]       level;

   always #5 clk = ~clk;

   sym_stream_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .IDLE_SYM(IDLE)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_sym(cmd_sym), .cmd_len(cmd_len),
      .sym_out(sym_out), .sym_valid(sym_valid),
      .busy(busy), .level(level)
   );

   int n_total = 0;
   int n_pass  = 0;

   function automatic void check(string name, int act, int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endfunction

   // ---------------- reference model ----------------
   // Queue of pending commands plus the number of valid cycles still to be
   // shown for the run on the output (0 = idle).
   logic [CNT_W+1:0] exp_q[$];
   logic [1:0]       m_sym = IDLE;
   int               m_rem = 0;
   logic [CNT_W+1:0] m_head;
   bit               m_can_push;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         exp_q.delete();
         m_rem = 0;
         m_sym = IDLE;
      end else if (flush) begin
         exp_q.delete();
         m_rem = 0;
      end else begin
         m_can_push = cmd_valid && (exp_q.size() != DEPTH);
         if (m_rem <= 1 && exp_q.size() > 0) begin
            m_head = exp_q.pop_front();
            m_sym  = m_head[CNT_W+1:CNT_W];
            m_rem  = int'(m_head[CNT_W-1:0]) + 1;
         end else if (m_rem > 0) begin
            m_rem--;
         end
         if (m_can_push) exp_q.push_back({cmd_sym, cmd_len});
      end
   end

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      check("sym_valid", int'(sym_valid), int'(m_rem > 0));
      check("sym_out",   int'(sym_out),   (m_rem > 0) ? int'(m_sym) : int'(IDLE));
      check("level",     int'(level),     exp_q.size());
      check("cmd_ready", int'(cmd_ready), int'(exp_q.size() != DEPTH));
      check("busy",      int'(busy),      int'((m_rem > 0) || (exp_q.size() > 0)));
   end

   // ---------------- driver tasks ----------------
   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Offer one command and hold it until an edge accepts it.
   task automatic push_cmd(input logic [1:0] s, input logic [CNT_W-1:0] l);
      bit acc;
      cmd_valid = 1'b1;
      cmd_sym   = s;
      cmd_len   = l;
      for (int w = 0; w < 200; w++) begin
         acc = cmd_ready;
         @(negedge clk);
         if (acc) begin
            cmd_valid = 1'b0;
            return;
         end
      end
      cmd_valid = 1'b0;
      check("push_timeout", 0, 1);
   endtask

   task automatic wait_level(input int lv);
      for (int w = 0; w < 60; w++) begin
         if (int'(level) == lv) return;
         @(negedge clk);
      end
      check("level_wait_timeout", 0, 1);
   endtask

   task automatic wait_valid();
      for (int w = 0; w < 20; w++) begin
         if (sym_valid) return;
         @(negedge clk);
      end
      check("valid_wait_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      for (int w = 0; w < 300; w++) begin
         if (!busy) return;
         @(negedge clk);
      end
      check("drain_timeout", 0, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      idle_cycles(3);
      rst = 1'b0;
      idle_cycles(2);
      check("reset_sym_out", int'(sym_out), 3);
      check("reset_level", int'(level), 0);
      check("reset_ready", int'(cmd_ready), 1);

      // Single run {1, len=2}: three valid cycles after the push edge's successor.
      cmd_valid = 1'b1; cmd_sym = 2'd1; cmd_len = 4'd2;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("s1_level_after_push", int'(level), 1);
      check("s1_no_bypass", int'(sym_valid), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("s1_run_sym", int'(sym_out), 1);
         check("s1_run_valid", int'(sym_valid), 1);
      end
      @(negedge clk);
      check("s1_end_sym", int'(sym_out), 3);
      check("s1_end_valid", int'(sym_valid), 0);
      check("s1_end_busy", int'(busy), 0);
      idle_cycles(2);

      // Three commands on consecutive edges: 1,0,0,2 then idle, no gap.
      cmd_valid = 1'b1; cmd_sym = 2'd1; cmd_len = 4'd0;
      @(negedge clk);
      cmd_sym = 2'd0; cmd_len = 4'd1;
      @(negedge clk);
      check("s2_sym0", int'(sym_out), 1);
      cmd_sym = 2'd2; cmd_len = 4'd0;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("s2_sym1", int'(sym_out), 0);
      @(negedge clk);
      check("s2_sym2", int'(sym_out), 0);
      @(negedge clk);
      check("s2_sym3", int'(sym_out), 2);
      check("s2_valid3", int'(sym_valid), 1);
      @(negedge clk);
      check("s2_idle_sym", int'(sym_out), 3);
      check("s2_idle_valid", int'(sym_valid), 0);
      idle_cycles(2);

      // Five long commands back-to-back fill the FIFO.
      push_cmd(2'd0, 4'd15);
      push_cmd(2'd1, 4'd15);
      push_cmd(2'd2, 4'd15);
      push_cmd(2'd3, 4'd15);
      push_cmd(2'd1, 4'd15);
      check("s3_full_level", int'(level), 4);
      check("s3_full_ready", int'(cmd_ready), 0);

      // Held command while full: accepted only on the edge after the pop.
      push_cmd(2'd2, 4'd15);
      check("s4_refill_level", int'(level), 4);
      check("s4_refill_ready", int'(cmd_ready), 0);

      // Flush mid-run with level 3 and a concurrent command.
      wait_level(3);
      flush = 1'b1; cmd_valid = 1'b1; cmd_sym = 2'd2; cmd_len = 4'd0;
      @(negedge clk);
      flush = 1'b0; cmd_valid = 1'b0;
      check("s5_level", int'(level), 0);
      check("s5_sym", int'(sym_out), 3);
      check("s5_valid", int'(sym_valid), 0);
      check("s5_busy", int'(busy), 0);
      idle_cycles(4);
      check("s5_still_idle", int'(sym_valid), 0);

      // Asynchronous reset between edges during a run.
      push_cmd(2'd1, 4'd5);
      push_cmd(2'd2, 4'd5);
      wait_valid();
      #2 rst = 1'b1;
      #1;
      check("s6_sym", int'(sym_out), 3);
      check("s6_valid", int'(sym_valid), 0);
      check("s6_level", int'(level), 0);
      check("s6_busy", int'(busy), 0);
      idle_cycles(2);
      rst = 1'b0;
      idle_cycles(5);
      check("s6_no_resume", int'(sym_valid), 0);
      check("s6_level_after", int'(level), 0);

      // Randomized traffic with occasional flush.
      for (int i = 0; i < 600; i++) begin
         flush     = ($urandom_range(0, 39) == 0);
         cmd_valid = ($urandom_range(0, 2) != 0);
         cmd_sym   = 2'($urandom_range(0, 3));
         cmd_len   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15))
                                                 : 4'($urandom_range(0, 3));
         @(negedge clk);
      end
      flush = 1'b0;
      cmd_valid = 1'b0;
      wait_drain();
      idle_cycles(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
